// File: rtl/potential_accumulator.sv
// Leaky-neuron accumulator: sums buffered FP32 weights onto the decayed potential and fires against V_THRESH.
// Optional macro SPIKE_RESET_EN: on fire, new_potential is V_RESET instead of the accumulated value.

module addition_subtraction (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        op,
  output logic [31:0] result
);
  logic [31:0] bx, hi, lo;
  logic [7:0]  e_hi, e_lo, d;
  logic [26:0] m_hi, m_lo, m_al, norm;
  logic [27:0] sum;
  logic [9:0]  exp_n, sh;
  logic [24:0] rnd;
  logic        a_nan, b_nan, a_inf, b_inf;

  always_comb begin
    bx    = {b[31] ^ op, b[30:0]};
    a_nan = (&a[30:23]) && (|a[22:0]);
    b_nan = (&b[30:23]) && (|b[22:0]);
    a_inf = (&a[30:23]) && (a[22:0] == 23'd0);
    b_inf = (&b[30:23]) && (b[22:0] == 23'd0);
    if (a[30:0] >= bx[30:0]) begin
      hi = a;
      lo = bx;
    end else begin
      hi = bx;
      lo = a;
    end
    // Subnormals use effective exponent 1 with no hidden bit; 3 extra bits are guard/round/sticky.
    e_hi = (hi[30:23] == 8'd0) ? 8'd1 : hi[30:23];
    e_lo = (lo[30:23] == 8'd0) ? 8'd1 : lo[30:23];
    m_hi = {|hi[30:23], hi[22:0], 3'b000};
    m_lo = {|lo[30:23], lo[22:0], 3'b000};
    d    = e_hi - e_lo;
    if (d >= 8'd27) m_al = {26'd0, |m_lo};
    else            m_al = (m_lo >> d) | {26'd0, |(m_lo & ((27'd1 << d) - 27'd1))};
    sum = (hi[31] ^ lo[31]) ? ({1'b0, m_hi} - {1'b0, m_al}) : ({1'b0, m_hi} + {1'b0, m_al});
    exp_n = {2'b00, e_hi};
    sh    = 10'd27;
    for (int i = 0; i < 27; i++) if (sum[i]) sh = 10'(26 - i);
    if (sum[27]) begin
      norm  = {sum[27:2], |sum[1:0]};
      exp_n = exp_n + 10'd1;
    end else begin
      if (sh > exp_n - 10'd1) sh = exp_n - 10'd1;
      norm  = sum[26:0] << sh;
      exp_n = exp_n - sh;
    end
    rnd = {1'b0, norm[26:3]} + {24'd0, norm[2] & (norm[1] | norm[0] | norm[3])};
    if (a_nan)                                   result = a | 32'h0040_0000;
    else if (b_nan)                              result = b | 32'h0040_0000;
    else if (a_inf && b_inf && (a[31] != bx[31])) result = 32'h7FC0_0000;
    else if (a_inf || b_inf)                     result = hi;
    else if (sum == 28'd0)                       result = {hi[31] & lo[31], 31'd0};
    else if (rnd[24])                            result = (exp_n >= 10'd254) ? {hi[31], 8'hFF, 23'd0}
                                                                             : {hi[31], 8'(exp_n + 10'd1), 23'd0};
    else if (!rnd[23])                           result = {hi[31], 8'h00, rnd[22:0]};
    else if (exp_n >= 10'd255)                   result = {hi[31], 8'hFF, 23'd0};
    else                                         result = {hi[31], exp_n[7:0], rnd[22:0]};
  end
endmodule

module potential_accumulator #(
  parameter logic [31:0] V_THRESH   = 32'h41F00000,
  parameter logic [31:0] V_RESET    = 32'h00000000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        decayed_valid,
  input  logic [31:0] decayed_potential,
  input  logic        weight_valid,
  input  logic [31:0] weight_in,
  output logic        weight_ready,
  input  logic        timestep_end,
  output logic [31:0] new_potential,
  output logic        potential_valid,
  output logic        spike_out,
  output logic        busy,
  output logic        drop_err
);
  localparam int AW = $clog2(FIFO_DEPTH);
`ifdef SPIKE_RESET_EN
  localparam bit SPIKE_RESET = 1'b1;
`else
  localparam bit SPIKE_RESET = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ACCUM, CHECK, EMIT} state_t;
  state_t      state;
  logic [31:0] acc, sum;
  logic [31:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        end_flag, rdy_en, full, empty, push, pop, fire;

  assign empty        = (wr_ptr == rd_ptr);
  assign full         = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign weight_ready = rdy_en && !full && !end_flag;
  assign push         = weight_valid && weight_ready;
  assign pop          = (state == ACCUM) && !empty;
  assign busy         = (state != IDLE);
  // Sign-magnitude compare is monotonic for positive floats, so integer >= suffices.
  assign fire         = !acc[31] && (acc[30:0] >= V_THRESH[30:0]);

  addition_subtraction u_add (
    .a      (acc),
    .b      (mem[rd_ptr[AW-1:0]]),
    .op     (1'b0),
    .result (sum)
  );

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= weight_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      acc             <= 32'd0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      end_flag        <= 1'b0;
      rdy_en          <= 1'b0;
      new_potential   <= 32'd0;
      potential_valid <= 1'b0;
      spike_out       <= 1'b0;
      drop_err        <= 1'b0;
    end else begin
      rdy_en          <= 1'b1;
      potential_valid <= 1'b0;
      spike_out       <= 1'b0;
      drop_err        <= decayed_valid && (state != IDLE);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (timestep_end && (state == IDLE || state == ACCUM)) end_flag <= 1'b1;
      case (state)
        IDLE: if (decayed_valid) begin
          acc   <= decayed_potential;
          state <= ACCUM;
        end
        ACCUM: begin
          if (pop)           acc   <= sum;
          else if (end_flag) state <= CHECK;
        end
        CHECK: begin
          potential_valid <= 1'b1;
          spike_out       <= fire;
          new_potential   <= (SPIKE_RESET && fire) ? V_RESET : acc;
          state           <= EMIT;
        end
        EMIT: begin
          end_flag <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_potential_accumulator.sv
// Scoreboard bench for potential_accumulator with a double-precision reference model.
module tb_potential_accumulator;
  localparam logic [31:0] V_TH = 32'h41F00000;
  localparam logic [31:0] V_RS = 32'h00000000;
`ifdef SPIKE_RESET_EN
  localparam bit RESET_EN = 1'b1;
`else
  localparam bit RESET_EN = 1'b0;
`endif

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        decayed_valid = 1'b0, weight_valid = 1'b0, timestep_end = 1'b0;
  logic [31:0] decayed_potential = 32'd0, weight_in = 32'd0;
  logic        weight_ready, potential_valid, spike_out, busy, drop_err;
  logic [31:0] new_potential;

  potential_accumulator dut (
    .clk(clk), .rst_n(rst_n), .decayed_valid(decayed_valid), .decayed_potential(decayed_potential),
    .weight_valid(weight_valid), .weight_in(weight_in), .weight_ready(weight_ready),
    .timestep_end(timestep_end), .new_potential(new_potential), .potential_valid(potential_valid),
    .spike_out(spike_out), .busy(busy), .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] np; logic spk; int lat;} exp_t;
  exp_t        sb[$];
  logic [31:0] pre_q[$], post_q[$];
  int checks = 0, errors = 0, cyc = 0, last_dv_cyc = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference arithmetic: FP32 values are widened to double, added, and rounded back to nearest-even.
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:0] == 31'd0) d = {f[31], 63'd0};
    else                  d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [30:0] mag;
    d = $realtobits(r);
    if (d[62:52] == 11'd0) return {d[63], 31'd0};
    mag = {8'(d[62:52] - 11'd896), d[51:29]};
    if (d[28:0] > 29'h10000000 || (d[28:0] == 29'h10000000 && mag[0])) mag = mag + 31'd1;
    return {d[63], mag};
  endfunction

  function automatic logic [31:0] rnd_fp(input int emin, input int emax);
    return {1'($urandom_range(0, 1)), 8'($urandom_range(emin, emax)), 23'($urandom)};
  endfunction

  function automatic exp_t model(input logic [31:0] dec, input logic [31:0] ws[$], input int lat);
    exp_t e;
    real  v;
    v = f2r(dec);
    foreach (ws[i]) v = f2r(r2f(v + f2r(ws[i])));
    e.spk = (v >= f2r(V_TH));
    e.np  = (RESET_EN && e.spk) ? V_RS : r2f(v);
    e.lat = lat;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (potential_valid) begin
        if (sb.size() == 0) check1("unexpected_valid", potential_valid, 1'b0);
        else begin
          e = sb.pop_front();
          check32("new_potential", new_potential, e.np);
          check1("spike_out", spike_out, e.spk);
          if (e.lat >= 0) check32("latency", 32'(cyc - last_dv_cyc), 32'(e.lat));
        end
      end else if (spike_out) check1("spike_without_valid", spike_out, 1'b0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_weight(input logic [31:0] w, output bit ok);
    weight_valid = 1'b1;
    weight_in    = w;
    ok           = weight_ready;
    tick();
    weight_valid = 1'b0;
  endtask

  task automatic push_wait(input logic [31:0] w, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) push_weight(w, ok);
    if (!ok) check1("weight_accept_timeout", ok, 1'b1);
  endtask

  task automatic pulse_end();
    timestep_end = 1'b1;
    tick();
    timestep_end = 1'b0;
  endtask

  task automatic pulse_dv(input logic [31:0] v, input bit mark);
    decayed_valid     = 1'b1;
    decayed_potential = v;
    tick();
    decayed_valid = 1'b0;
    if (mark) last_dv_cyc = cyc;
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      if (!busy) done = 1'b1;
      else tick();
    end
    if (!done) check1("idle_timeout", busy, 1'b0);
  endtask

  // Pre-mode: weights and timestep_end land before decayed_valid, so latency is known.
  task automatic run_txn(input logic [31:0] dec, input bit use_exp, input logic [31:0] np, input logic spk);
    logic [31:0] acc_q[$];
    exp_t        e;
    bit          ok;
    acc_q = {};
    foreach (pre_q[i]) begin
      push_wait(pre_q[i], ok);
      if (ok) acc_q.push_back(pre_q[i]);
    end
    if (post_q.size() == 0) begin
      e = model(dec, acc_q, acc_q.size() + 2);
      if (use_exp) begin e.np = np; e.spk = spk; end
      sb.push_back(e);
      pulse_end();
      pulse_dv(dec, 1'b1);
    end else begin
      pulse_dv(dec, 1'b1);
      foreach (post_q[i]) begin
        push_wait(post_q[i], ok);
        if (ok) acc_q.push_back(post_q[i]);
      end
      e = model(dec, acc_q, -1);
      sb.push_back(e);
      pulse_end();
    end
    wait_idle();
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] acc_q[$];
    exp_t        e;
    bit          ok;
    int          n_ok;

    #2;
    check32("reset_new_potential", new_potential, 32'd0);
    check1("reset_valid", potential_valid, 1'b0);
    check1("reset_spike", spike_out, 1'b0);
    check1("reset_busy", busy, 1'b0);
    check1("reset_drop_err", drop_err, 1'b0);
    #20 rst_n = 1'b1;
    tick();
    check1("ready_after_reset", weight_ready, 1'b1);

    pre_q = {32'h3F800000, 32'h3F800000}; post_q = {};
    run_txn(32'h415ED852, 1'b1, 32'h417ED852, 1'b0);

    pre_q = {32'h40400000}; post_q = {};
    run_txn(32'h41DED852, 1'b1, RESET_EN ? 32'h00000000 : 32'h41F6D852, 1'b1);

    pre_q = {}; post_q = {};
    run_txn(32'hC1200000, 1'b1, 32'hC1200000, 1'b0);

    // Six back-to-back offers into an idle, depth-4 buffer.
    acc_q = {};
    n_ok  = 0;
    for (int i = 0; i < 6; i++) begin
      push_weight(32'h3F800000 + 32'(i) * 32'h00100000, ok);
      if (ok) begin n_ok++; acc_q.push_back(32'h3F800000 + 32'(i) * 32'h00100000); end
      if (i == 3) check1("ready_low_when_full", weight_ready, 1'b0);
    end
    check32("accepted_count", 32'(n_ok), 32'd4);
    sb.push_back(model(32'h40000000, acc_q, 6));
    pulse_end();
    pulse_dv(32'h40000000, 1'b1);
    wait_idle();
    tick();

    // Stray decayed_valid during ACCUM.
    pre_q = {32'h3F000000, 32'hBE800000, 32'h40A00000};
    foreach (pre_q[i]) push_wait(pre_q[i], ok);
    sb.push_back(model(32'h41000000, pre_q, 5));
    pulse_end();
    pulse_dv(32'h41000000, 1'b1);
    pulse_dv(32'h42C80000, 1'b0);
    check1("drop_err_strobe", drop_err, 1'b1);
    tick();
    check1("drop_err_single", drop_err, 1'b0);
    wait_idle();
    tick();

    // Reset mid-ACCUM discards everything.
    for (int i = 0; i < 3; i++) push_wait(32'h3F800000, ok);
    pulse_dv(32'h40000000, 1'b0);
    tick();
    rst_n = 1'b0;
    #1;
    check32("midreset_new_potential", new_potential, 32'd0);
    check1("midreset_valid", potential_valid, 1'b0);
    check1("midreset_spike", spike_out, 1'b0);
    check1("midreset_busy", busy, 1'b0);
    check1("midreset_drop_err", drop_err, 1'b0);
    tick();
    tick();
    #2 rst_n = 1'b1;
    tick();
    check1("ready_after_midreset", weight_ready, 1'b1);
    pre_q = {}; post_q = {};
    run_txn(32'h40400000, 1'b1, 32'h40400000, 1'b0);

    for (int t = 0; t < 40; t++) begin
      pre_q  = {};
      post_q = {};
      for (int i = 0; i < int'($urandom_range(0, 4)); i++) pre_q.push_back(rnd_fp(118, 129));
      if ($urandom_range(0, 1) == 1)
        for (int i = 0; i < int'($urandom_range(1, 3)); i++) post_q.push_back(rnd_fp(118, 129));
      run_txn(rnd_fp(120, 132), 1'b0, 32'd0, 1'b0);
    end

    repeat (5) tick();
    check32("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
